// File: rtl/sfb_axi_pixel_writer.sv
// AXI3 write master: packs a 24-bit RGB stream into 16-beat x 256-bit bursts in the DDR framebuffer.
// Optional sticky write-response error check: define SFB_PIXEL_WRITER_BRESP_CHK_EN.
module sfb_axi_pixel_writer #(
  parameter logic [31:0] VIDEO_FB_RAM = 32'h1E00_0000,
  parameter logic [31:0] FRAME_BYTES  = 32'd8294400,
  parameter logic [3:0]  BURST_LEN    = 4'd15
) (
  input  logic         outport_clk_i,
  input  logic         outport_nrst_i,
  input  logic         enable_i,
  input  logic [31:0]  base_addr_i,
  input  logic         pix_valid_i,
  output logic         pix_ready_o,
  input  logic [23:0]  pix_data_i,
  input  logic         pix_sof_i,
  output logic [31:0]  outport_awaddr_o,
  output logic [3:0]   outport_awlen_o,
  output logic [7:0]   outport_awid_o,
  output logic [2:0]   outport_awsize_o,
  output logic [1:0]   outport_awburst_o,
  output logic [1:0]   outport_awlock_o,
  output logic [2:0]   outport_awprot_o,
  output logic [3:0]   outport_awcache_o,
  output logic         outport_awvalid_o,
  input  logic         outport_awready_i,
  output logic [255:0] outport_wdata_o,
  output logic [31:0]  outport_wstrb_o,
  output logic         outport_wlast_o,
  output logic         outport_wvalid_o,
  output logic [7:0]   outport_wid_o,
  input  logic         outport_wready_i,
  input  logic [1:0]   outport_bresp_i,
  input  logic [7:0]   outport_bid_i,
  input  logic         outport_bvalid_i,
  output logic         outport_bready_o,
  output logic         busy_o,
  output logic         frame_done_o,
  output logic         err_o,
  output logic [2:0]   dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid & ready are both high; a raised valid and its payload hold until then.
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_AW, S_W, S_B} state_t;

  state_t         r_state, w_next;
  logic [31:0]    r_addr, r_base;
  logic [6:0]     r_pix_cnt;
  logic [3:0]     r_beat;
  logic [255:0]   r_buf [16];
  logic           w_pix_acc;
  logic [31:0]    w_addr_inc;
  logic           w_wrap;
  logic [3:0]     w_wr_beat;
  logic [2:0]     w_wr_lane;

  assign w_addr_inc = r_addr + 32'd512;
  assign w_wrap     = (w_addr_inc == (r_base + FRAME_BYTES));
  // An SOF pixel restarts packing at lane 0 of beat 0, discarding any partial fill.
  assign w_wr_beat  = pix_sof_i ? 4'd0 : r_pix_cnt[6:3];
  assign w_wr_lane  = pix_sof_i ? 3'd0 : r_pix_cnt[2:0];

  always_comb begin
    w_next            = r_state;
    pix_ready_o       = 1'b0;
    outport_awvalid_o = 1'b0;
    outport_wvalid_o  = 1'b0;
    outport_bready_o  = 1'b0;
    frame_done_o      = 1'b0;
    w_pix_acc         = 1'b0;
    case (r_state)
      S_IDLE: if (enable_i) w_next = S_FILL;
      S_FILL: begin
        pix_ready_o = enable_i;
        w_pix_acc   = enable_i & pix_valid_i;
        if (w_pix_acc && !pix_sof_i && r_pix_cnt == 7'd127) w_next = S_AW;
        else if (!enable_i && r_pix_cnt == 7'd0)            w_next = S_IDLE;
      end
      S_AW: begin
        outport_awvalid_o = 1'b1;
        if (outport_awready_i) w_next = S_W;
      end
      S_W: begin
        outport_wvalid_o = 1'b1;
        if (outport_wready_i && r_beat == BURST_LEN) w_next = S_B;
      end
      S_B: begin
        outport_bready_o = 1'b1;
        if (outport_bvalid_i) begin
          frame_done_o = w_wrap;
          w_next       = S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge outport_clk_i) begin
    if (!outport_nrst_i) begin
      r_state   <= S_IDLE;
      r_addr    <= VIDEO_FB_RAM;
      r_base    <= VIDEO_FB_RAM;
      r_pix_cnt <= 7'd0;
      r_beat    <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_pix_acc) begin
        if (pix_sof_i) begin
          r_base    <= base_addr_i;
          r_addr    <= base_addr_i;
          r_pix_cnt <= 7'd1;
        end else begin
          r_pix_cnt <= r_pix_cnt + 7'd1;
        end
      end
      if (outport_wvalid_o && outport_wready_i) r_beat <= r_beat + 4'd1;
      if (outport_bready_o && outport_bvalid_i) begin
        r_addr    <= w_wrap ? r_base : w_addr_inc;
        r_pix_cnt <= 7'd0;
      end
    end
  end

  // Pixel storage carries no reset; it is only read after being fully written.
  always_ff @(posedge outport_clk_i) begin
    if (w_pix_acc) r_buf[w_wr_beat][{w_wr_lane, 5'd0} +: 32] <= {8'h00, pix_data_i};
  end

`ifdef SFB_PIXEL_WRITER_BRESP_CHK_EN
  logic r_err;
  always_ff @(posedge outport_clk_i) begin
    if (!outport_nrst_i) begin
      r_err <= 1'b0;
    end else if (outport_bready_o && outport_bvalid_i &&
                 (outport_bresp_i != 2'b00 || outport_bid_i != 8'd0)) begin
      r_err <= 1'b1;
    end
  end
  assign err_o = r_err;
`else
  logic w_unused_bresp;
  assign w_unused_bresp = ^{outport_bresp_i, outport_bid_i};
  assign err_o = 1'b0;
`endif

  assign outport_awaddr_o  = r_addr;
  assign outport_awlen_o   = BURST_LEN;
  assign outport_awid_o    = 8'd0;
  assign outport_awsize_o  = 3'b101;
  assign outport_awburst_o = 2'b01;
  assign outport_awlock_o  = 2'b00;
  assign outport_awprot_o  = 3'b000;
  assign outport_awcache_o = 4'b0000;
  assign outport_wdata_o   = r_buf[r_beat];
  assign outport_wstrb_o   = '1;
  assign outport_wlast_o   = (r_beat == BURST_LEN);
  assign outport_wid_o     = 8'd0;
  assign busy_o            = (r_state != S_IDLE);
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_sfb_axi_pixel_writer.sv
// Directed bench for sfb_axi_pixel_writer; uses a 4-burst frame so the frame wrap is reachable quickly.
module tb_sfb_axi_pixel_writer;

  localparam logic [31:0] FB_BYTES = 32'd2048;
`ifdef SFB_PIXEL_WRITER_BRESP_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic         clk, nrst, enable;
  logic [31:0]  base_addr;
  logic         pix_valid, pix_ready, pix_sof;
  logic [23:0]  pix_data;
  logic [31:0]  awaddr;
  logic [3:0]   awlen, awcache;
  logic [7:0]   awid, wid, bid;
  logic [2:0]   awsize, awprot, dbg_state;
  logic [1:0]   awburst, awlock, bresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         busy, frame_done, err;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];

  sfb_axi_pixel_writer #(.FRAME_BYTES(FB_BYTES)) dut (
    .outport_clk_i(clk), .outport_nrst_i(nrst), .enable_i(enable),
    .base_addr_i(base_addr), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .pix_data_i(pix_data), .pix_sof_i(pix_sof),
    .outport_awaddr_o(awaddr), .outport_awlen_o(awlen), .outport_awid_o(awid),
    .outport_awsize_o(awsize), .outport_awburst_o(awburst), .outport_awlock_o(awlock),
    .outport_awprot_o(awprot), .outport_awcache_o(awcache), .outport_awvalid_o(awvalid),
    .outport_awready_i(awready), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
    .outport_wlast_o(wlast), .outport_wvalid_o(wvalid), .outport_wid_o(wid),
    .outport_wready_i(wready), .outport_bresp_i(bresp), .outport_bid_i(bid),
    .outport_bvalid_i(bvalid), .outport_bready_o(bready), .busy_o(busy),
    .frame_done_o(frame_done), .err_o(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_px(input logic [23:0] val, input logic sof);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = val;
    pix_sof   = sof;
    while (!pix_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("pix_ready_wait", pix_ready, 1);
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_fill(input logic [23:0] first, input logic sof);
    logic [255:0] beat;
    logic [23:0]  val;
    beat = '0;
    for (int i = 0; i < 128; i++) begin
      val = first + 24'(i);
      send_px(val, sof && i == 0);
      beat[(i % 8) * 32 +: 32] = {8'h00, val};
      if (i % 8 == 7) exp_q.push_back(beat);
    end
  endtask

  task automatic do_burst(input logic [31:0] exp_addr, input bit stall, input logic [1:0] resp,
                          input logic exp_fd, input int abort_beat);
    int n, k;
    logic [255:0] exp_beat;
    n = 0;
    while (!awvalid && n < 64) begin
      tick();
      n++;
    end
    if (!stall) chk("aw_latency", 32'(n), 0);
    k = stall ? $urandom_range(0, 3) : 0;
    repeat (k) begin
      tick();
      chk("aw_hold_valid", awvalid, 1);
      chk("aw_hold_addr", awaddr, exp_addr);
    end
    chk("awaddr", awaddr, exp_addr);
    chk("aw_ctrl", {awlen, awsize, awburst, awid, awlock, awprot, awcache},
        {4'd15, 3'b101, 2'b01, 8'd0, 2'b00, 3'b000, 4'b0000});
    chk("pix_ready_aw", pix_ready, 0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("aw_drop", awvalid, 0);
    for (int b = 0; b < 16; b++) begin
      exp_beat = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (b == abort_beat) begin
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("rst_wvalid", wvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_awaddr", awaddr, 32'h1E00_0000);
        chk("rst_err", err, 0);
        exp_q.delete();
        return;
      end
      k = stall ? $urandom_range(0, 3) : 0;
      repeat (k) begin
        tick();
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_data", wdata, exp_beat);
        chk("pix_ready_w", pix_ready, 0);
      end
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, exp_beat);
      chk("wlast", wlast, b == 15);
      chk("wstrb_wid", {wstrb, wid}, {32'hFFFF_FFFF, 8'd0});
      wready = 1'b1;
      tick();
      wready = 1'b0;
    end
    k = stall ? $urandom_range(0, 3) : 0;
    repeat (k) begin
      chk("b_wait_bready", bready, 1);
      tick();
    end
    chk("bready", bready, 1);
    bvalid = 1'b1;
    bresp  = resp;
    #1;
    chk("frame_done", frame_done, exp_fd);
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    chk("frame_done_pulse", frame_done, 0);
    chk("bready_drop", bready, 0);
  endtask

  // stimulus
  initial begin
    nrst = 1'b0; enable = 1'b0; base_addr = 32'h1E00_0000;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 8'd0;
    tick();
    tick();
    nrst = 1'b1;
    chk("reset_outs", {busy, awvalid, wvalid, bready, pix_ready, frame_done, err},
        7'd0);
    chk("reset_state", dbg_state, 3'd0);
    chk("reset_awaddr", awaddr, 32'h1E00_0000);
    enable = 1'b1;
    tick();
    chk("fill_busy", busy, 1);
    chk("fill_ready", pix_ready, 1);

    // first burst at the default base, pixel values 0..127
    send_fill(24'h000000, 1'b1);
    chk("beat0_lane0_q", exp_q[0][31:0], 32'h0000_0000);
    chk("beat15_lane7_q", exp_q[15][255:224], 32'h0000_007F);
    do_burst(32'h1E00_0000, 1'b0, 2'b00, 1'b0, -1);

    // frame of four bursts, then wrap back to base
    base_addr = 32'h1000_0000;
    send_fill(24'h010000, 1'b1);
    do_burst(32'h1000_0000, 1'b0, 2'b00, 1'b0, -1);
    for (int i = 1; i < 4; i++) begin
      send_fill(24'h020000 + 24'(i * 256), 1'b0);
      do_burst(32'h1000_0000 + 32'(i * 512), 1'b0, 2'b00, i == 3, -1);
    end
    send_fill(24'h030000, 1'b0);
    do_burst(32'h1000_0000, 1'b0, 2'b00, 1'b0, -1);

    // random stalls on every channel
    send_fill(24'h100000, 1'b0);
    do_burst(32'h1000_0200, 1'b1, 2'b00, 1'b0, -1);
    send_fill(24'h200000, 1'b0);
    do_burst(32'h1000_0400, 1'b1, 2'b00, 1'b0, -1);

    // partial fill holds with enable low, then SOF drops it and rebases
    for (int i = 0; i < 50; i++) send_px(24'hAA0000 + 24'(i), 1'b0);
    enable = 1'b0;
    tick();
    chk("partial_hold_busy", busy, 1);
    chk("partial_hold_ready", pix_ready, 0);
    tick();
    chk("partial_hold_state", dbg_state, 3'd1);
    enable = 1'b1;
    base_addr = 32'h1800_0000;
    send_fill(24'h550000, 1'b1);
    chk("sof_beat0_q", exp_q[0][31:0], 32'h0055_0000);
    do_burst(32'h1800_0000, 1'b0, 2'b00, 1'b0, -1);

    // write-response error on the second burst; address still advances
    base_addr = 32'h1400_0000;
    send_fill(24'h400000, 1'b1);
    do_burst(32'h1400_0000, 1'b0, 2'b00, 1'b0, -1);
    chk("err_clean", err, 0);
    send_fill(24'h410000, 1'b0);
    do_burst(32'h1400_0200, 1'b0, 2'b10, 1'b0, -1);
    chk("err_set", err, ERR_EN);
    send_fill(24'h420000, 1'b0);
    do_burst(32'h1400_0400, 1'b0, 2'b00, 1'b0, -1);
    chk("err_sticky", err, ERR_EN);
    enable = 1'b0;
    tick();
    chk("idle_on_disable", busy, 0);
    chk("idle_no_ready", pix_ready, 0);

    // reset during the W phase at beat 7, then resume from the reset base
    enable = 1'b1;
    send_fill(24'h600000, 1'b0);
    do_burst(32'h1400_0600, 1'b0, 2'b00, 1'b0, 7);
    send_fill(24'h700000, 1'b0);
    do_burst(32'h1E00_0000, 1'b0, 2'b00, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
